// File: rtl/e203_exu_oitf_px_if.sv
// Dispatch/retire/status bundle of the outstanding-instruction track FIFO.
// master drives requests and operand info; slave (the OITF) returns status and hazard flags.
interface e203_exu_oitf_px_if #(
  parameter int unsigned ITAG_W  = 2,
  parameter int unsigned RFIDX_W = 5,
  parameter int unsigned PC_W    = 32
);
  logic               flush;
  logic               dis_ena;
  logic               dis_ready;
  logic [ITAG_W-1:0]  dis_ptr;
  logic               ret_ena;
  logic [ITAG_W-1:0]  ret_ptr;
  logic [RFIDX_W-1:0] ret_rdidx;
  logic               ret_rdwen;
  logic               ret_rdfpu;
  logic [PC_W-1:0]    ret_pc;
  logic               disp_i_rs1en;
  logic               disp_i_rs2en;
  logic               disp_i_rs3en;
  logic               disp_i_rdwen;
  logic               disp_i_rs1fpu;
  logic               disp_i_rs2fpu;
  logic               disp_i_rs3fpu;
  logic               disp_i_rdfpu;
  logic [RFIDX_W-1:0] disp_i_rs1idx;
  logic [RFIDX_W-1:0] disp_i_rs2idx;
  logic [RFIDX_W-1:0] disp_i_rs3idx;
  logic [RFIDX_W-1:0] disp_i_rdidx;
  logic [PC_W-1:0]    disp_i_pc;
  logic               oitfrd_match_disprs1;
  logic               oitfrd_match_disprs2;
  logic               oitfrd_match_disprs3;
  logic               oitfrd_match_disprd;
  logic               oitf_empty;
  logic               oitf_full;
  logic [ITAG_W:0]    oitf_cnt;

  modport master (
    output flush, dis_ena, ret_ena,
    output disp_i_rs1en, disp_i_rs2en, disp_i_rs3en, disp_i_rdwen,
    output disp_i_rs1fpu, disp_i_rs2fpu, disp_i_rs3fpu, disp_i_rdfpu,
    output disp_i_rs1idx, disp_i_rs2idx, disp_i_rs3idx, disp_i_rdidx, disp_i_pc,
    input  dis_ready, dis_ptr, ret_ptr, ret_rdidx, ret_rdwen, ret_rdfpu, ret_pc,
    input  oitfrd_match_disprs1, oitfrd_match_disprs2, oitfrd_match_disprs3,
    input  oitfrd_match_disprd, oitf_empty, oitf_full, oitf_cnt
  );

  modport slave (
    input  flush, dis_ena, ret_ena,
    input  disp_i_rs1en, disp_i_rs2en, disp_i_rs3en, disp_i_rdwen,
    input  disp_i_rs1fpu, disp_i_rs2fpu, disp_i_rs3fpu, disp_i_rdfpu,
    input  disp_i_rs1idx, disp_i_rs2idx, disp_i_rs3idx, disp_i_rdidx, disp_i_pc,
    output dis_ready, dis_ptr, ret_ptr, ret_rdidx, ret_rdwen, ret_rdfpu, ret_pc,
    output oitfrd_match_disprs1, oitfrd_match_disprs2, oitfrd_match_disprs3,
    output oitfrd_match_disprd, oitf_empty, oitf_full, oitf_cnt
  );
endinterface

// File: rtl/e203_exu_oitf_px.sv
// Outstanding-instruction track FIFO: records long-latency instructions and flags RAW/WAW hazards.
// Define E203_OITF_PC_EN to store a PC per entry and return it on ret_pc.
module e203_exu_oitf_px #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned ITAG_W  = 2,
  parameter int unsigned RFIDX_W = 5,
  parameter int unsigned PC_W    = 32
) (
  input logic               clk,
  input logic               rst,
  e203_exu_oitf_px_if.slave bus
);

  localparam logic [ITAG_W-1:0] LastIdx = ITAG_W'(DEPTH - 1);

  logic [ITAG_W-1:0]  alc_ptr_q, alc_ptr_d;
  logic [ITAG_W-1:0]  rtr_ptr_q, rtr_ptr_d;
  logic               alc_flg_q, alc_flg_d;
  logic               rtr_flg_q, rtr_flg_d;
  logic [DEPTH-1:0]   vld_q, vld_d;

  logic [RFIDX_W-1:0] rdidx_q [DEPTH];
  logic [DEPTH-1:0]   rdwen_q;
  logic [DEPTH-1:0]   rdfpu_q;

  logic               ptr_eq;
  logic               oitf_empty;
  logic               oitf_full;
  logic [ITAG_W:0]    oitf_cnt;
  logic               dis_fire;
  logic               ret_fire;

  logic [DEPTH-1:0]   hit_rs1, hit_rs2, hit_rs3, hit_rd;

  // Occupancy status from pointers and wrap flags
  assign ptr_eq     = (alc_ptr_q == rtr_ptr_q);
  assign oitf_empty = ptr_eq & (alc_flg_q == rtr_flg_q);
  assign oitf_full  = ptr_eq & (alc_flg_q != rtr_flg_q);

  always_comb begin
    if (alc_flg_q == rtr_flg_q) begin
      oitf_cnt = {1'b0, alc_ptr_q} - {1'b0, rtr_ptr_q};
    end else begin
      oitf_cnt = (ITAG_W+1)'(DEPTH) - {1'b0, rtr_ptr_q} + {1'b0, alc_ptr_q};
    end
  end

  // Flush suppresses both handshakes so no payload is written on a flushed cycle
  assign dis_fire = bus.dis_ena & ~oitf_full & ~bus.flush;
  assign ret_fire = bus.ret_ena & ~oitf_empty & ~bus.flush;

  always_comb begin
    alc_ptr_d = alc_ptr_q;
    alc_flg_d = alc_flg_q;
    rtr_ptr_d = rtr_ptr_q;
    rtr_flg_d = rtr_flg_q;
    vld_d     = vld_q;

    if (ret_fire) begin
      vld_d[rtr_ptr_q] = 1'b0;
      if (rtr_ptr_q == LastIdx) begin
        rtr_ptr_d = '0;
        rtr_flg_d = ~rtr_flg_q;
      end else begin
        rtr_ptr_d = rtr_ptr_q + ITAG_W'(1);
      end
    end

    // Dispatch and retire never target the same slot: full blocks one, empty the other
    if (dis_fire) begin
      vld_d[alc_ptr_q] = 1'b1;
      if (alc_ptr_q == LastIdx) begin
        alc_ptr_d = '0;
        alc_flg_d = ~alc_flg_q;
      end else begin
        alc_ptr_d = alc_ptr_q + ITAG_W'(1);
      end
    end

    if (bus.flush) begin
      alc_ptr_d = '0;
      alc_flg_d = 1'b0;
      rtr_ptr_d = '0;
      rtr_flg_d = 1'b0;
      vld_d     = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      alc_ptr_q <= '0;
      alc_flg_q <= 1'b0;
      rtr_ptr_q <= '0;
      rtr_flg_q <= 1'b0;
      vld_q     <= '0;
    end else begin
      alc_ptr_q <= alc_ptr_d;
      alc_flg_q <= alc_flg_d;
      rtr_ptr_q <= rtr_ptr_d;
      rtr_flg_q <= rtr_flg_d;
      vld_q     <= vld_d;
    end
  end

  // Payload is qualified by the valid bits, so it carries no reset
  always_ff @(posedge clk) begin
    if (dis_fire & ~rst) begin
      rdidx_q[alc_ptr_q] <= bus.disp_i_rdidx;
      rdwen_q[alc_ptr_q] <= bus.disp_i_rdwen;
      rdfpu_q[alc_ptr_q] <= bus.disp_i_rdfpu;
    end
  end

`ifdef E203_OITF_PC_EN
  logic [PC_W-1:0] pc_q [DEPTH];

  always_ff @(posedge clk) begin
    if (dis_fire & ~rst) begin
      pc_q[alc_ptr_q] <= bus.disp_i_pc;
    end
  end

  assign bus.ret_pc = pc_q[rtr_ptr_q];
`else
  logic unused_pc;

  assign unused_pc  = ^bus.disp_i_pc;
  assign bus.ret_pc = '0;
`endif

  // Hazard compare against registered entries only; a same-cycle dispatch is not visible
  for (genvar g = 0; g < DEPTH; g++) begin : g_ent
    logic live;

    assign live       = vld_q[g] & rdwen_q[g];
    assign hit_rs1[g] = live & bus.disp_i_rs1en & (rdfpu_q[g] == bus.disp_i_rs1fpu) &
                        (rdidx_q[g] == bus.disp_i_rs1idx);
    assign hit_rs2[g] = live & bus.disp_i_rs2en & (rdfpu_q[g] == bus.disp_i_rs2fpu) &
                        (rdidx_q[g] == bus.disp_i_rs2idx);
    assign hit_rs3[g] = live & bus.disp_i_rs3en & (rdfpu_q[g] == bus.disp_i_rs3fpu) &
                        (rdidx_q[g] == bus.disp_i_rs3idx);
    assign hit_rd[g]  = live & bus.disp_i_rdwen & (rdfpu_q[g] == bus.disp_i_rdfpu) &
                        (rdidx_q[g] == bus.disp_i_rdidx);
  end

  assign bus.oitfrd_match_disprs1 = |hit_rs1;
  assign bus.oitfrd_match_disprs2 = |hit_rs2;
  assign bus.oitfrd_match_disprs3 = |hit_rs3;
  assign bus.oitfrd_match_disprd  = |hit_rd;

  assign bus.dis_ready  = ~oitf_full;
  assign bus.dis_ptr    = alc_ptr_q;
  assign bus.ret_ptr    = rtr_ptr_q;
  assign bus.ret_rdidx  = rdidx_q[rtr_ptr_q];
  assign bus.ret_rdwen  = rdwen_q[rtr_ptr_q];
  assign bus.ret_rdfpu  = rdfpu_q[rtr_ptr_q];
  assign bus.oitf_empty = oitf_empty;
  assign bus.oitf_full  = oitf_full;
  assign bus.oitf_cnt   = oitf_cnt;

`ifndef SYNTHESIS
  // The valid vector must always agree with the pointer-derived count
  a_cnt_vld : assert property (@(posedge clk) disable iff (rst)
    ($countones(vld_q) == int'(oitf_cnt)));
  a_cnt_max : assert property (@(posedge clk) disable iff (rst)
    (int'(oitf_cnt) <= int'(DEPTH)));
`endif

endmodule

// File: tb/tb_e203_exu_oitf_px.sv
// Directed bench for e203_exu_oitf_px: a DEPTH=4 instance for most scenarios and a
// DEPTH=3 instance for non-power-of-2 pointer wrap.
module tb_e203_exu_oitf_px;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

`ifdef E203_OITF_PC_EN
  localparam bit PcOn = 1'b1;
`else
  localparam bit PcOn = 1'b0;
`endif
  localparam logic [31:0] PcBase = 32'h8000_0100;

  e203_exu_oitf_px_if #(.ITAG_W(2), .RFIDX_W(5), .PC_W(32)) b4 ();
  e203_exu_oitf_px_if #(.ITAG_W(2), .RFIDX_W(5), .PC_W(32)) b3 ();

  e203_exu_oitf_px #(.DEPTH(4), .ITAG_W(2), .RFIDX_W(5), .PC_W(32)) dut4 (
    .clk(clk), .rst(rst), .bus(b4)
  );
  e203_exu_oitf_px #(.DEPTH(3), .ITAG_W(2), .RFIDX_W(5), .PC_W(32)) dut3 (
    .clk(clk), .rst(rst), .bus(b3)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    b4.flush = 0; b4.dis_ena = 0; b4.ret_ena = 0;
    b4.disp_i_rs1en = 0; b4.disp_i_rs2en = 0; b4.disp_i_rs3en = 0; b4.disp_i_rdwen = 0;
    b4.disp_i_rs1fpu = 0; b4.disp_i_rs2fpu = 0; b4.disp_i_rs3fpu = 0; b4.disp_i_rdfpu = 0;
    b4.disp_i_rs1idx = 0; b4.disp_i_rs2idx = 0; b4.disp_i_rs3idx = 0; b4.disp_i_rdidx = 0;
    b4.disp_i_pc = 0;
    b3.flush = 0; b3.dis_ena = 0; b3.ret_ena = 0;
    b3.disp_i_rs1en = 0; b3.disp_i_rs2en = 0; b3.disp_i_rs3en = 0; b3.disp_i_rdwen = 0;
    b3.disp_i_rs1fpu = 0; b3.disp_i_rs2fpu = 0; b3.disp_i_rs3fpu = 0; b3.disp_i_rdfpu = 0;
    b3.disp_i_rs1idx = 0; b3.disp_i_rs2idx = 0; b3.disp_i_rs3idx = 0; b3.disp_i_rdidx = 0;
    b3.disp_i_pc = 0;
  endtask

  task automatic test_reset();
    rst = 1; idle(); tick(); tick(); rst = 0; #1;
    checks++; if (b4.oitf_empty !== 1'b1) begin errors++;
      $display("FAIL reset_empty: got %0b exp 1", b4.oitf_empty); end
    checks++; if (b4.oitf_full !== 1'b0) begin errors++;
      $display("FAIL reset_full: got %0b exp 0", b4.oitf_full); end
    checks++; if (b4.dis_ready !== 1'b1) begin errors++;
      $display("FAIL reset_ready: got %0b exp 1", b4.dis_ready); end
    checks++; if (b4.oitf_cnt !== 3'd0) begin errors++;
      $display("FAIL reset_cnt: got %0d exp 0", b4.oitf_cnt); end
    checks++; if ({b4.dis_ptr, b4.ret_ptr} !== 4'b0) begin errors++;
      $display("FAIL reset_ptrs: got %0d/%0d exp 0/0", b4.dis_ptr, b4.ret_ptr); end
    b4.disp_i_rs1en = 1; b4.disp_i_rs2en = 1; b4.disp_i_rs3en = 1; b4.disp_i_rdwen = 1; #1;
    checks++;
    if ({b4.oitfrd_match_disprs1, b4.oitfrd_match_disprs2, b4.oitfrd_match_disprs3,
         b4.oitfrd_match_disprd} !== 4'b0) begin errors++;
      $display("FAIL reset_match: got %b%b%b%b exp 0000", b4.oitfrd_match_disprs1,
               b4.oitfrd_match_disprs2, b4.oitfrd_match_disprs3, b4.oitfrd_match_disprd);
    end
    checks++; if (b3.oitf_empty !== 1'b1) begin errors++;
      $display("FAIL reset_empty3: got %0b exp 1", b3.oitf_empty); end
    idle();
  endtask

  task automatic test_fill();
    for (int i = 0; i < 4; i++) begin
      checks++; if (b4.dis_ptr !== 2'(i)) begin errors++;
        $display("FAIL fill_disptr%0d: got %0d exp %0d", i, b4.dis_ptr, i); end
      b4.dis_ena = 1; b4.disp_i_rdidx = 5'(i + 1); b4.disp_i_rdwen = 1;
      b4.disp_i_pc = PcBase + 32'(4 * i);
      tick();
      checks++; if (b4.oitf_cnt !== 3'(i + 1)) begin errors++;
        $display("FAIL fill_cnt%0d: got %0d exp %0d", i, b4.oitf_cnt, i + 1); end
    end
    b4.dis_ena = 0; #1;
    checks++; if ({b4.oitf_full, b4.dis_ready, b4.oitf_empty} !== 3'b100) begin errors++;
      $display("FAIL fill_status: got full/rdy/empty %b%b%b exp 100",
               b4.oitf_full, b4.dis_ready, b4.oitf_empty); end
    checks++; if (b4.ret_rdidx !== 5'd1) begin errors++;
      $display("FAIL fill_oldest: got %0d exp 1", b4.ret_rdidx); end
    checks++; if (b4.ret_pc !== (PcOn ? PcBase : 32'h0)) begin errors++;
      $display("FAIL fill_retpc: got %0h exp %0h", b4.ret_pc, PcOn ? PcBase : 32'h0); end
    b4.dis_ena = 1; b4.disp_i_rdidx = 5'd31; tick(); b4.dis_ena = 0;
    checks++; if (b4.dis_ptr !== 2'd0) begin errors++;
      $display("FAIL fill_blocked_ptr: got %0d exp 0", b4.dis_ptr); end
    checks++; if (b4.oitf_cnt !== 3'd4) begin errors++;
      $display("FAIL fill_blocked_cnt: got %0d exp 4", b4.oitf_cnt); end
    idle();
  endtask

  task automatic test_full_dis_ret();
    b4.dis_ena = 1; b4.ret_ena = 1; b4.disp_i_rdidx = 5'd9; b4.disp_i_rdwen = 1;
    tick(); b4.dis_ena = 0;
    checks++; if (b4.oitf_cnt !== 3'd3) begin errors++;
      $display("FAIL fullboth_cnt: got %0d exp 3", b4.oitf_cnt); end
    checks++; if ({b4.ret_ptr, b4.dis_ptr} !== {2'd1, 2'd0}) begin errors++;
      $display("FAIL fullboth_ptrs: got %0d/%0d exp 1/0", b4.ret_ptr, b4.dis_ptr); end
    for (int k = 2; k <= 4; k++) begin
      checks++; if (b4.ret_rdidx !== 5'(k)) begin errors++;
        $display("FAIL drain_order%0d: got %0d exp %0d", k, b4.ret_rdidx, k); end
      tick();
    end
    checks++; if (b4.oitf_empty !== 1'b1) begin errors++;
      $display("FAIL drain_empty: got %0b exp 1", b4.oitf_empty); end
    tick(); b4.ret_ena = 0;
    checks++; if ({b4.oitf_empty, b4.oitf_cnt, b4.ret_ptr} !== {1'b1, 3'd0, 2'd0}) begin
      errors++;
      $display("FAIL ret_on_empty: got empty=%0b cnt=%0d rptr=%0d exp 1/0/0",
               b4.oitf_empty, b4.oitf_cnt, b4.ret_ptr); end
    idle();
  endtask

  task automatic test_back_to_back();
    b4.dis_ena = 1; b4.disp_i_rdwen = 1; b4.disp_i_rdidx = 5'd10; tick();
    b4.disp_i_rdidx = 5'd11; tick();
    b4.ret_ena = 1; b4.disp_i_rdidx = 5'd12; tick();
    b4.dis_ena = 0; b4.ret_ena = 0;
    checks++; if (b4.oitf_cnt !== 3'd2) begin errors++;
      $display("FAIL b2b_cnt: got %0d exp 2", b4.oitf_cnt); end
    checks++; if (b4.ret_rdidx !== 5'd11) begin errors++;
      $display("FAIL b2b_oldest: got %0d exp 11", b4.ret_rdidx); end
    checks++; if ({b4.ret_ptr, b4.dis_ptr} !== {2'd1, 2'd3}) begin errors++;
      $display("FAIL b2b_ptrs: got %0d/%0d exp 1/3", b4.ret_ptr, b4.dis_ptr); end
    idle();
  endtask

  task automatic test_flush();
    b4.flush = 1; b4.dis_ena = 1; b4.ret_ena = 1; b4.disp_i_rdidx = 5'd13; tick();
    idle();
    checks++; if ({b4.oitf_empty, b4.oitf_cnt} !== {1'b1, 3'd0}) begin errors++;
      $display("FAIL flush_empty: got empty=%0b cnt=%0d exp 1/0", b4.oitf_empty, b4.oitf_cnt);
    end
    checks++; if ({b4.dis_ptr, b4.ret_ptr} !== 4'b0) begin errors++;
      $display("FAIL flush_ptrs: got %0d/%0d exp 0/0", b4.dis_ptr, b4.ret_ptr); end
  endtask

  task automatic test_match();
    b4.dis_ena = 1; b4.disp_i_rdwen = 1; b4.disp_i_rdidx = 5'd5; tick();
    b4.disp_i_rdwen = 0; b4.disp_i_rdidx = 5'd7; tick();
    b4.dis_ena = 0; b4.disp_i_rdidx = 0;
    b4.disp_i_rs2en = 1; b4.disp_i_rs2idx = 5'd5; #1;
    checks++; if (b4.oitfrd_match_disprs2 !== 1'b1) begin errors++;
      $display("FAIL match_rs2_hit: got %0b exp 1", b4.oitfrd_match_disprs2); end
    b4.disp_i_rs2fpu = 1; #1;
    checks++; if (b4.oitfrd_match_disprs2 !== 1'b0) begin errors++;
      $display("FAIL match_rs2_fpu: got %0b exp 0", b4.oitfrd_match_disprs2); end
    b4.disp_i_rs2fpu = 0; b4.disp_i_rs2en = 0; #1;
    checks++; if (b4.oitfrd_match_disprs2 !== 1'b0) begin errors++;
      $display("FAIL match_rs2_en: got %0b exp 0", b4.oitfrd_match_disprs2); end
    b4.disp_i_rs3en = 1; b4.disp_i_rs3idx = 5'd7; #1;
    checks++; if (b4.oitfrd_match_disprs3 !== 1'b0) begin errors++;
      $display("FAIL match_rs3_nowen: got %0b exp 0", b4.oitfrd_match_disprs3); end
    b4.disp_i_rdwen = 1; b4.disp_i_rdidx = 5'd5; #1;
    checks++; if (b4.oitfrd_match_disprd !== 1'b1) begin errors++;
      $display("FAIL match_rd_hit: got %0b exp 1", b4.oitfrd_match_disprd); end
    b4.disp_i_rdfpu = 1; #1;
    checks++; if (b4.oitfrd_match_disprd !== 1'b0) begin errors++;
      $display("FAIL match_rd_fpu: got %0b exp 0", b4.oitfrd_match_disprd); end
    b4.disp_i_rdfpu = 0; b4.disp_i_rs1en = 1; b4.disp_i_rs1idx = 5'd9; b4.disp_i_rdidx = 5'd9;
    b4.dis_ena = 1; #1;
    checks++; if (b4.oitfrd_match_disprs1 !== 1'b0) begin errors++;
      $display("FAIL match_no_bypass: got %0b exp 0", b4.oitfrd_match_disprs1); end
    tick(); b4.dis_ena = 0;
    checks++; if (b4.oitfrd_match_disprs1 !== 1'b1) begin errors++;
      $display("FAIL match_rs1_next: got %0b exp 1", b4.oitfrd_match_disprs1); end
    b4.ret_ena = 1; tick(); b4.ret_ena = 0;
    b4.disp_i_rs2en = 1; b4.disp_i_rs2idx = 5'd5; #1;
    checks++; if (b4.oitfrd_match_disprs2 !== 1'b0) begin errors++;
      $display("FAIL match_after_ret: got %0b exp 0", b4.oitfrd_match_disprs2); end
    checks++; if (b4.oitf_cnt !== 3'd2) begin errors++;
      $display("FAIL match_cnt: got %0d exp 2", b4.oitf_cnt); end
    idle();
  endtask

  task automatic test_reset_traffic();
    b4.dis_ena = 1; b4.disp_i_rdwen = 1; b4.disp_i_rdidx = 5'd14; tick();
    checks++; if (b4.oitf_cnt !== 3'd3) begin errors++;
      $display("FAIL rsttraf_pre_cnt: got %0d exp 3", b4.oitf_cnt); end
    rst = 1; b4.ret_ena = 1; b4.disp_i_rdidx = 5'd15; tick();
    rst = 0; b4.dis_ena = 0; b4.ret_ena = 0;
    checks++; if ({b4.oitf_empty, b4.oitf_cnt} !== {1'b1, 3'd0}) begin errors++;
      $display("FAIL rsttraf_empty: got empty=%0b cnt=%0d exp 1/0", b4.oitf_empty, b4.oitf_cnt);
    end
    checks++; if ({b4.dis_ptr, b4.ret_ptr} !== 4'b0) begin errors++;
      $display("FAIL rsttraf_ptrs: got %0d/%0d exp 0/0", b4.dis_ptr, b4.ret_ptr); end
    b4.dis_ena = 1; b4.disp_i_rdidx = 5'd3; tick(); b4.dis_ena = 0;
    checks++; if ({b4.oitf_cnt, b4.ret_rdidx, b4.dis_ptr} !== {3'd1, 5'd3, 2'd1}) begin
      errors++;
      $display("FAIL rsttraf_disp: got cnt=%0d rd=%0d dptr=%0d exp 1/3/1",
               b4.oitf_cnt, b4.ret_rdidx, b4.dis_ptr); end
    b4.disp_i_rdwen = 0; b4.disp_i_rs1en = 1; b4.disp_i_rs1idx = 5'd15; #1;
    checks++; if (b4.oitfrd_match_disprs1 !== 1'b0) begin errors++;
      $display("FAIL rsttraf_stale: got %0b exp 0", b4.oitfrd_match_disprs1); end
    idle();
  endtask

  task automatic test_wrap3();
    for (int k = 0; k < 7; k++) begin
      checks++; if (b3.dis_ptr !== 2'(k % 3)) begin errors++;
        $display("FAIL wrap_dptr%0d: got %0d exp %0d", k, b3.dis_ptr, k % 3); end
      b3.dis_ena = 1; b3.disp_i_rdwen = 1; b3.disp_i_rdidx = 5'(20 + k); tick();
      b3.dis_ena = 0;
      checks++; if ({b3.ret_rdidx, b3.ret_ptr} !== {5'(20 + k), 2'(k % 3)}) begin errors++;
        $display("FAIL wrap_ret%0d: got rd=%0d rptr=%0d exp %0d/%0d",
                 k, b3.ret_rdidx, b3.ret_ptr, 20 + k, k % 3); end
      b3.ret_ena = 1; tick(); b3.ret_ena = 0;
      checks++; if (b3.oitf_empty !== 1'b1) begin errors++;
        $display("FAIL wrap_empty%0d: got %0b exp 1", k, b3.oitf_empty); end
    end
    b3.ret_ena = 1; tick(); b3.ret_ena = 0;
    checks++; if ({b3.ret_ptr, b3.oitf_cnt, b3.oitf_empty} !== {2'd1, 3'd0, 1'b1}) begin
      errors++;
      $display("FAIL wrap_idle_ret: got rptr=%0d cnt=%0d empty=%0b exp 1/0/1",
               b3.ret_ptr, b3.oitf_cnt, b3.oitf_empty); end
    for (int j = 0; j < 3; j++) begin
      b3.dis_ena = 1; b3.disp_i_rdidx = 5'(27 + j); tick();
    end
    b3.dis_ena = 0;
    checks++; if ({b3.oitf_full, b3.oitf_cnt, b3.dis_ptr} !== {1'b1, 3'd3, 2'd1}) begin
      errors++;
      $display("FAIL wrap_full: got full=%0b cnt=%0d dptr=%0d exp 1/3/1",
               b3.oitf_full, b3.oitf_cnt, b3.dis_ptr); end
    for (int j = 0; j < 3; j++) begin
      checks++; if ({b3.ret_rdidx, b3.ret_ptr} !== {5'(27 + j), 2'((1 + j) % 3)}) begin
        errors++;
        $display("FAIL wrap_drain%0d: got rd=%0d rptr=%0d exp %0d/%0d",
                 j, b3.ret_rdidx, b3.ret_ptr, 27 + j, (1 + j) % 3); end
      b3.ret_ena = 1; tick(); b3.ret_ena = 0;
    end
    checks++; if ({b3.oitf_empty, b3.ret_ptr} !== {1'b1, 2'd1}) begin errors++;
      $display("FAIL wrap_end: got empty=%0b rptr=%0d exp 1/1", b3.oitf_empty, b3.ret_ptr);
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_fill();
    test_full_dis_ret();
    test_back_to_back();
    test_flush();
    test_match();
    test_reset_traffic();
    test_wrap3();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/e203_exu_oitf_px.md
E203_EXU_OITF_PX -- requirements
Module: e203_exu_oitf_px

Interface
REQ-001 Parameter DEPTH, default 4, number of entries; any integer 1..16.
REQ-002 Parameter ITAG_W, default 2, tag width; at least clog2(DEPTH), minimum 1.
REQ-003 Parameter RFIDX_W, default 5, register index width.
REQ-004 Parameter PC_W, default 32, PC width.
REQ-005 clk  in  1  single clock; all state updates on its rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 flush  in  1  discards all entries.
REQ-008 dis_ena  in  1  dispatch request for a long instruction.
REQ-009 dis_ready  out  1  accepts dispatch; equals ~oitf_full.
REQ-010 dis_ptr  out  ITAG_W  tag the next accepted dispatch gets; equals the allocation pointer.
REQ-011 ret_ena  in  1  retire the oldest entry.
REQ-012 ret_ptr  out  ITAG_W  tag of the oldest entry; equals the retire pointer.
REQ-013 ret_rdidx / ret_rdwen / ret_rdfpu / ret_pc  out  RFIDX_W/1/1/PC_W  fields of the entry at ret_ptr.
REQ-014 disp_i_rsNen, disp_i_rsNfpu (N=1..3), disp_i_rdwen, disp_i_rdfpu  in  1 each  operand enables and FPU-file selects.
REQ-015 disp_i_rsNidx (N=1..3), disp_i_rdidx  in  RFIDX_W each  operand register indices.
REQ-016 disp_i_pc  in  PC_W  PC of the dispatching instruction.
REQ-017 oitfrd_match_disprs1/2/3, oitfrd_match_disprd  out  1 each  hazard flags.
REQ-018 oitf_empty, oitf_full  out  1 each  occupancy status.
REQ-019 oitf_cnt  out  ITAG_W+1  number of valid entries.

Function
REQ-020 Dispatch is accepted when dis_ena & dis_ready & ~flush; dis_ena & ~dis_ready changes no state.
REQ-021 An accepted dispatch writes rdidx, rdwen, rdfpu and pc into entry dis_ptr, sets that entry's valid bit, and advances the allocation pointer.
REQ-022 Retire is accepted when ret_ena & ~oitf_empty & ~flush; it clears the valid bit at ret_ptr and advances the retire pointer; ret_ena while empty is ignored.
REQ-023 Pointers wrap from DEPTH-1 to 0, including for non-power-of-2 DEPTH; each pointer carries a wrap flag that toggles on every wrap.
REQ-024 oitf_empty = pointers equal and flags equal; oitf_full = pointers equal and flags differ; oitf_cnt is always consistent with the flags and pointers.
REQ-025 Simultaneous accepted dispatch and retire leave oitf_cnt unchanged.
REQ-026 When full, only the retire is accepted in that cycle; when empty, only the dispatch is accepted.
REQ-027 oitfrd_match_disprsN = OR over entries of (valid & rdwen & disp_i_rsNen & rdfpu==disp_i_rsNfpu & rdidx==disp_i_rsNidx).
REQ-028 oitfrd_match_disprd uses the same terms with disp_i_rdwen, disp_i_rdfpu and disp_i_rdidx.
REQ-029 All match flags and status outputs are combinational from registered state; there is no bypass of same-cycle dispatch.
REQ-030 Flush takes priority over dispatch and retire in the same cycle: next cycle all valid bits are 0, both pointers and flags are 0, and oitf_cnt is 0.
REQ-031 The ret_* fields are combinational reads at ret_ptr; when empty their values are don't-care.
REQ-032 DEPTH=1 degenerates to a single valid bit with both pointers fixed at 0.

Reset
REQ-033 On rst high at a clock edge, valid bits, pointers and flags are set to 0.
REQ-034 After reset, oitf_empty=1, oitf_full=0, dis_ready=1, oitf_cnt=0, dis_ptr=0, ret_ptr=0, and all match flags are 0.
REQ-035 Payload registers (rdidx, pc, rdwen, rdfpu) are not reset.
REQ-036 Reset during ongoing traffic overrides all other inputs in that cycle.

Configuration
REQ-037 Macro E203_OITF_PC_EN: when defined, per-entry PC storage is present and ret_pc returns the stored PC.
REQ-038 When E203_OITF_PC_EN is undefined, there is no PC storage, ret_pc is constant 0, and disp_i_pc is ignored.

Verification
REQ-039 DEPTH=4: after reset, dispatch rdidx 1..4 on consecutive cycles -> oitf_full=1, oitf_cnt=4, dis_ready=0; a 5th dis_ena leaves dis_ptr=0.
REQ-040 DEPTH=3: run 7 dispatch/retire pairs, then retire -> pointers wrap 2->0, flags toggle, ret_rdidx follows dispatch order.
REQ-041 Entry rdidx=5, rdwen=1, rdfpu=0 -> match_disprs2=1 for rs2idx=5, rs2en=1, rs2fpu=0; the flag is 0 when rs2fpu=1 or rs2en=0.
REQ-042 Full (cnt=4) with dis_ena and ret_ena in the same cycle -> next cycle cnt=3 and no new entry is written.
REQ-043 cnt=2 with flush, dis_ena and ret_ena all high -> next cycle oitf_empty=1, cnt=0, dis_ptr=0, ret_ptr=0.
REQ-044 rst asserted at cnt=3 -> next cycle oitf_empty=1; a following dispatch gets dis_ptr=0.
